// File: rtl/calc_controller.sv
// calc_controller: top-level sequencing FSM for the calculator datapath.
// Captures operand A and the opcode, then operand B, from the switches on
// successive enter presses. It then launches the arithmetic unit with a
// one-cycle start pulse and waits for done, giving up after a bounded
// number of cycles.
//
// Ports:
//   clk, rst          - system clock, asynchronous active-high reset
//   btn_enter         - debounced single-cycle pulse, advances entry
//   btn_clear         - debounced single-cycle pulse, aborts to ENTER_A
//   sw, op_in         - operand and opcode switches
//   alu_done          - arithmetic unit completion (level), sampled only in WAIT_ALU
//   operand_a/b       - registered operands
//   op_code           - registered opcode
//   alu_start         - single-cycle launch pulse
//   en1/en2/en3       - one-hot display source selects (A, B, result)
//   result_valid      - result on display is valid
//   error             - arithmetic unit timed out
//   state_dbg         - encoded state for LEDs/ILA
module calc_controller #(
    parameter int unsigned WIDTH          = 6,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_enter,
    input  logic             btn_clear,
    input  logic [WIDTH-1:0] sw,
    input  logic [1:0]       op_in,
    input  logic             alu_done,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [1:0]       op_code,
    output logic             alu_start,
    output logic             en1,
    output logic             en2,
    output logic             en3,
    output logic             result_valid,
    output logic             error,
    output logic [2:0]       state_dbg
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StEnterA  = 3'd0,
        StEnterB  = 3'd1,
        StWaitAlu = 3'd2,
        StShowRes = 3'd3,
        StError   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  operand_a_q, operand_a_d;
    logic [WIDTH-1:0]  operand_b_q, operand_b_d;
    logic [1:0]        op_code_q, op_code_d;
    logic              alu_start_q, alu_start_d;
    logic              result_valid_q, result_valid_d;
    logic              error_q, error_d;
    logic [CntW-1:0]   counter_q, counter_d;

    always_comb begin
        state_d        = state_q;
        operand_a_d    = operand_a_q;
        operand_b_d    = operand_b_q;
        op_code_d      = op_code_q;
        alu_start_d    = 1'b0;  // launch pulse lasts exactly one cycle
        result_valid_d = result_valid_q;
        error_d        = error_q;
        counter_d      = counter_q;

        if (btn_clear) begin
            // Clear outranks enter and done in the same cycle.
            state_d        = StEnterA;
            operand_a_d    = '0;
            operand_b_d    = '0;
            op_code_d      = '0;
            result_valid_d = 1'b0;
            error_d        = 1'b0;
            counter_d      = '0;
        end else begin
            unique case (state_q)
                StEnterA: begin
                    if (btn_enter) begin
                        operand_a_d = sw;
                        op_code_d   = op_in;
                        state_d     = StEnterB;
                    end
                end
                StEnterB: begin
                    if (btn_enter) begin
                        operand_b_d = sw;
                        counter_d   = '0;
                        alu_start_d = 1'b1;
                        state_d     = StWaitAlu;
                    end
                end
                StWaitAlu: begin
                    // Done wins over a timeout landing in the same cycle.
                    if (alu_done) begin
                        result_valid_d = 1'b1;
                        state_d        = StShowRes;
                    end else if (counter_q == CntLast) begin
                        error_d = 1'b1;
                        state_d = StError;
                    end else begin
                        counter_d = counter_q + CntW'(1);
                    end
                end
                StShowRes: begin
                    if (btn_enter) begin
                        result_valid_d = 1'b0;
                        state_d        = StEnterA;
                    end
                end
                StError: begin
                    if (btn_enter) begin
                        error_d = 1'b0;
                        state_d = StEnterA;
                    end
                end
                default: state_d = StEnterA;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StEnterA;
            operand_a_q    <= '0;
            operand_b_q    <= '0;
            op_code_q      <= '0;
            alu_start_q    <= 1'b0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
            counter_q      <= '0;
        end else begin
            state_q        <= state_d;
            operand_a_q    <= operand_a_d;
            operand_b_q    <= operand_b_d;
            op_code_q      <= op_code_d;
            alu_start_q    <= alu_start_d;
            result_valid_q <= result_valid_d;
            error_q        <= error_d;
            counter_q      <= counter_d;
        end
    end

    // Display selects are decoded purely from the state register, so they
    // are glitch-free with respect to inputs and always one-hot. WAIT_ALU
    // keeps showing operand B so a stale result never appears.
    assign en1 = (state_q == StEnterA);
    assign en2 = (state_q == StEnterB) || (state_q == StWaitAlu);
    assign en3 = (state_q == StShowRes) || (state_q == StError);

    assign operand_a    = operand_a_q;
    assign operand_b    = operand_b_q;
    assign op_code      = op_code_q;
    assign alu_start    = alu_start_q;
    assign result_valid = result_valid_q;
    assign error        = error_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller; expected values are queued when the
// stimulus is driven and popped when the DUT output is sampled.
module tb_calc_controller;

    localparam int unsigned W = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         btn_enter, btn_clear, alu_done;
    logic [W-1:0] sw;
    logic [1:0]   op_in;
    logic [W-1:0] operand_a, operand_b;
    logic [1:0]   op_code;
    logic         alu_start, en1, en2, en3, result_valid, error;
    logic [2:0]   state_dbg;

    calc_controller #(
        .WIDTH         (W),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_enter   (btn_enter),
        .btn_clear   (btn_clear),
        .sw          (sw),
        .op_in       (op_in),
        .alu_done    (alu_done),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .op_code     (op_code),
        .alu_start   (alu_start),
        .en1         (en1),
        .en2         (en2),
        .en3         (en3),
        .result_valid(result_valid),
        .error       (error),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %0d required an expectation", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) n_pass++;
            else $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
        end
    endtask

    // Every cycle passes through here, so the one-hot select check runs each cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        n_checks++;
        assert ($onehot({en1, en2, en3})) n_pass++;
        else $error("FAIL onehot: observed %b expected one-hot", {en1, en2, en3});
    endtask

    task automatic press_enter();
        btn_enter = 1'b1;
        tick();
        btn_enter = 1'b0;
    endtask

    task automatic enter_ab(input logic [W-1:0] a, input logic [1:0] op,
                            input logic [W-1:0] b);
        sw = a; op_in = op;
        press_enter();
        sw = b;
        press_enter();
    endtask

    initial begin
        rst = 1'b1; btn_enter = 1'b0; btn_clear = 1'b0; alu_done = 1'b0;
        sw = '0; op_in = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        push("rst_state", 0); push("rst_en1", 1); push("rst_opa", 0);
        push("rst_start", 0); push("rst_valid", 0); push("rst_err", 0);
        pop_check(state_dbg); pop_check(en1); pop_check(operand_a);
        pop_check(alu_start); pop_check(result_valid); pop_check(error);

        // Capture A and opcode
        sw = 6'd5; op_in = 2'd1;
        push("a_state", 1); push("a_opa", 5); push("a_op", 1); push("a_en2", 1);
        press_enter();
        pop_check(state_dbg); pop_check(operand_a); pop_check(op_code); pop_check(en2);

        // Capture B, launch, done 3 cycles after start
        sw = 6'd9;
        push("b_state", 2); push("b_start", 1); push("b_opb", 9); push("b_en2", 1);
        press_enter();
        pop_check(state_dbg); pop_check(alu_start); pop_check(operand_b); pop_check(en2);
        push("start_drop", 0);
        tick();
        pop_check(alu_start);
        tick();
        push("wait3_state", 2);
        tick();
        pop_check(state_dbg);
        alu_done = 1'b1;
        push("done_state", 3); push("done_en3", 1); push("done_valid", 1);
        tick();
        alu_done = 1'b0;
        pop_check(state_dbg); pop_check(en3); pop_check(result_valid);
        push("ack_state", 0); push("ack_en1", 1); push("ack_valid", 0); push("ack_hold_a", 5);
        press_enter();
        pop_check(state_dbg); pop_check(en1); pop_check(result_valid); pop_check(operand_a);

        // Timeout: ERROR after exactly 4 WAIT_ALU cycles
        enter_ab(6'd3, 2'd2, 6'd7);
        tick(); tick();
        push("to_wait", 2);
        tick();
        pop_check(state_dbg);
        push("to_state", 4); push("to_err", 1); push("to_en3", 1); push("to_valid", 0);
        tick();
        pop_check(state_dbg); pop_check(error); pop_check(en3); pop_check(result_valid);
        push("err_ack_state", 0); push("err_ack_err", 0);
        press_enter();
        pop_check(state_dbg); pop_check(error);

        // Done coincident with the timeout cycle: done wins
        enter_ab(6'd1, 2'd3, 6'd2);
        tick(); tick(); tick();
        alu_done = 1'b1;
        push("race_state", 3); push("race_err", 0);
        tick();
        alu_done = 1'b0;
        pop_check(state_dbg); pop_check(error);
        press_enter();

        // alu_done in ENTER_A is ignored
        alu_done = 1'b1;
        push("done_idle_state", 0);
        tick();
        alu_done = 1'b0;
        pop_check(state_dbg);

        // Clear and enter together in ENTER_B
        sw = 6'd12; op_in = 2'd2;
        press_enter();
        btn_clear = 1'b1; btn_enter = 1'b1; sw = 6'd33;
        push("clr_state", 0); push("clr_opa", 0); push("clr_opb", 0);
        push("clr_op", 0); push("clr_start", 0);
        tick();
        btn_clear = 1'b0; btn_enter = 1'b0;
        pop_check(state_dbg); pop_check(operand_a); pop_check(operand_b);
        pop_check(op_code); pop_check(alu_start);
        push("clr_start2", 0);
        tick();
        pop_check(alu_start);

        // Async reset between edges in the first WAIT_ALU cycle
        enter_ab(6'd21, 2'd1, 6'd42);
        #2 rst = 1'b1;
        #1;
        push("arst_state", 0); push("arst_start", 0); push("arst_opa", 0);
        push("arst_opb", 0); push("arst_en1", 1); push("arst_en2", 0);
        pop_check(state_dbg); pop_check(alu_start); pop_check(operand_a);
        pop_check(operand_b); pop_check(en1); pop_check(en2);
        tick();
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
